fwd_hazard_ctrl: RTL

- Sequencing controller for the EX-stage operand-B mux (and operand-A forwarding) of the 5-stage core.
- Keeps a shadow pipeline of destination-register info for EX, MEM and WB.
- Produces registered per-instruction select codes for the mux, and inserts a one-cycle load-use stall.
- Also squashes on a branch flush.
- Sits between decode (ID) and the EX-stage mux/ALU.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 16 +
 rtl/fwd_hazard_ctrl_fwd_match.sv | 26 ++
 rtl/fwd_hazard_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared select codes and controller state encoding for the EX-stage operand forwarding logic.
package fwd_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      BSEL_REG   = 2'b00,
      BSEL_IMM   = 2'b01,
      BSEL_ALU   = 2'b10,
      BSEL_DATAD = 2'b11
   } bsel_e;

   typedef enum logic {
      RUN     = 1'b0,
      LDSTALL = 1'b1
   } ctrl_state_e;

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_match.sv
// Combinational forward-source picker for one operand: EX producer beats MEM producer, x0 never forwarded.
// Zero latency, no flow control.
module fwd_hazard_ctrl_fwd_match
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] src,
   input  logic              ex_valid,
   input  logic              ex_we,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_valid,
   input  logic              mem_we,
   input  logic [REG_AW-1:0] mem_rd,
   output logic [1:0]        sel
);

   always_comb begin
      sel = BSEL_REG;
      if (ex_valid && ex_we && (ex_rd != '0) && (src == ex_rd))
         sel = BSEL_ALU;
      else if (mem_valid && mem_we && (mem_rd != '0) && (src == mem_rd))
         sel = BSEL_DATAD;
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Operand forwarding select and load-use stall controller between ID and the EX mux.
// Selects are registered one cycle after ID; stall_o is combinational and lasts exactly one cycle.
module fwd_hazard_ctrl
   import fwd_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_we_i,
   input  logic              id_load_i,
   input  logic              id_use_rs1_i,
   input  logic              id_use_rs2_i,
   input  logic              id_use_imm_i,
   input  logic              flush_i,
   output logic [1:0]        asel_o,
   output logic [1:0]        bsel_o,
   output logic [1:0]        regbsel_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              load;
   } shadow_t;

   shadow_t     ex_q, mem_q, wb_q, ex_d;
   ctrl_state_e state_q, state_d;
   logic        hz, bubble;
   logic [1:0]  fwd_a, fwd_b;
   logic [1:0]  asel_d, bsel_d, regbsel_d;

   // WB shadow is kept for pipeline visibility only; nothing forwards from it directly.
   logic        unused_shadow;
   assign unused_shadow = ^{wb_q, mem_q.load};

   fwd_hazard_ctrl_fwd_match #(.REG_AW(REG_AW)) u_match_rs1 (
      .src       (id_rs1_i),
      .ex_valid  (ex_q.valid),
      .ex_we     (ex_q.we),
      .ex_rd     (ex_q.rd),
      .mem_valid (mem_q.valid),
      .mem_we    (mem_q.we),
      .mem_rd    (mem_q.rd),
      .sel       (fwd_a)
   );

   fwd_hazard_ctrl_fwd_match #(.REG_AW(REG_AW)) u_match_rs2 (
      .src       (id_rs2_i),
      .ex_valid  (ex_q.valid),
      .ex_we     (ex_q.we),
      .ex_rd     (ex_q.rd),
      .mem_valid (mem_q.valid),
      .mem_we    (mem_q.we),
      .mem_rd    (mem_q.rd),
      .sel       (fwd_b)
   );

   // A load in EX cannot feed its dependent until it reaches WB, so hold ID one cycle.
   always_comb begin
      hz = id_valid_i && ex_q.valid && ex_q.load && ex_q.we && (ex_q.rd != '0) &&
           ((id_use_rs1_i && (id_rs1_i == ex_q.rd)) ||
            (id_use_rs2_i && (id_rs2_i == ex_q.rd)));
      stall_o = hz && (state_q == RUN) && !flush_i && !rst;
      bubble  = stall_o || flush_i || !id_valid_i;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (stall_o) state_d = LDSTALL;
         LDSTALL: state_d = RUN;
         default: state_d = RUN;
      endcase
      if (flush_i)
         state_d = RUN;
   end

   always_comb begin
      asel_d    = BSEL_REG;
      bsel_d    = BSEL_REG;
      regbsel_d = BSEL_REG;
      ex_d      = '0;
      if (!bubble) begin
         if (id_use_rs1_i)
            asel_d = fwd_a;
         if (id_use_imm_i)
            bsel_d = BSEL_IMM;
         else if (id_use_rs2_i)
            bsel_d = fwd_b;
         if (id_use_rs2_i)
            regbsel_d = fwd_b;
         ex_d.valid = 1'b1;
         ex_d.rd    = id_rd_i;
         ex_d.we    = id_we_i;
         ex_d.load  = id_load_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         state_q     <= RUN;
         asel_o      <= BSEL_REG;
         bsel_o      <= BSEL_REG;
         regbsel_o   <= BSEL_REG;
         stall_cnt_o <= '0;
      end else begin
         ex_q      <= ex_d;
         mem_q     <= ex_q;
         wb_q      <= mem_q;
         state_q   <= state_d;
         asel_o    <= asel_d;
         bsel_o    <= bsel_d;
         regbsel_o <= regbsel_d;
         if (stall_o && (stall_cnt_o != {CNT_W{1'b1}}))
            stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
